// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 matrix keypad model driven by key codes.
// Emulates press bounce, hold, release bounce and inter-key gap.
module keypad_emulator #(
    parameter int HOLD_CYCLES   = 1000000,
    parameter int GAP_CYCLES    = 500000,
    parameter int BOUNCE_CYCLES = 50000,
    parameter int BOUNCE_PERIOD = 5000,
    parameter int CW            = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [3:0] col,
    output logic [3:0] fila,
    output logic       contact,
    output logic       busy,
    output logic       key_done
);

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_IN,
        HOLD,
        BOUNCE_OUT,
        GAP
    } state_t;

    localparam bit HAS_BOUNCE = (BOUNCE_CYCLES > 0);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] BNC_LAST  =
        CW'(HAS_BOUNCE ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [CW-1:0] PER_LAST  =
        CW'(BOUNCE_PERIOD > 0 ? BOUNCE_PERIOD - 1 : 0);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] pcnt, pcnt_n;
    logic [3:0]    code, code_n;
    logic          contact_n;
    logic          done_n;

    // State, phase counters, latched code and registered contact.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pcnt     <= '0;
            code     <= '0;
            contact  <= 1'b0;
            key_done <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pcnt     <= pcnt_n;
            code     <= code_n;
            contact  <= contact_n;
            key_done <= done_n;
        end
    end

    // Next-state logic; every phase change clears both counters.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        pcnt_n    = '0;
        code_n    = code;
        contact_n = contact;
        done_n    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (key_valid) begin
                    code_n    = key_code;
                    contact_n = 1'b1;
                    state_n   = HAS_BOUNCE ? BOUNCE_IN : HOLD;
                end
            end
            BOUNCE_IN, BOUNCE_OUT: begin
                pcnt_n = pcnt + CW'(1);
                if (pcnt == PER_LAST) begin
                    pcnt_n    = '0;
                    contact_n = !contact;
                end
                if (cnt == BNC_LAST) begin
                    cnt_n  = '0;
                    pcnt_n = '0;
                    if (state == BOUNCE_IN) begin
                        state_n   = HOLD;
                        contact_n = 1'b1;
                    end else begin
                        state_n   = GAP;
                        contact_n = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_n     = '0;
                    contact_n = 1'b0;
                    state_n   = HAS_BOUNCE ? BOUNCE_OUT : GAP;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n   = IDLE;
                cnt_n     = '0;
                contact_n = 1'b0;
            end
        endcase
    end

    // Row return: only the latched key's row, only under its column.
    always_comb begin
        fila = 4'b1111;
        if (contact && !col[code[1:0]])
            fila[code[3:2]] = 1'b0;
    end

    assign key_ready = (state == IDLE);
    assign busy      = !key_ready;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: randomized and directed checks of two
// keypad_emulator instances (no bounce / bounce) against a phase model.
module tb_keypad_emulator;

    localparam int HOLD = 20;
    localparam int GAP  = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       key_valid = 1'b0;
    logic [3:0] col = 4'hF;

    logic [1:0] rdy, bsy, don, con;
    logic [7:0] fil;

    int checks = 0;
    int errors = 0;

    bit       active [2];
    int       k      [2];
    logic [3:0] mcode [2];
    bit       mdone  [2];

    always #5 clk = ~clk;

    keypad_emulator #(
        .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP),
        .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(1), .CW(8)
    ) dut0 (
        .clk(clk), .rst(rst), .key_code(key_code),
        .key_valid(key_valid), .key_ready(rdy[0]),
        .col(col), .fila(fil[3:0]), .contact(con[0]),
        .busy(bsy[0]), .key_done(don[0])
    );

    keypad_emulator #(
        .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP),
        .BOUNCE_CYCLES(8), .BOUNCE_PERIOD(2), .CW(8)
    ) dut1 (
        .clk(clk), .rst(rst), .key_code(key_code),
        .key_valid(key_valid), .key_ready(rdy[1]),
        .col(col), .fila(fil[7:4]), .contact(con[1]),
        .busy(bsy[1]), .key_done(don[1])
    );

    function automatic int bcyc(int d);
        return (d == 0) ? 0 : 8;
    endfunction

    function automatic int bper(int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int total(int d);
        return 2 * bcyc(d) + HOLD + GAP;
    endfunction

    // Contact level kk cycles after acceptance, from the phase lengths.
    function automatic bit exp_contact(int d, int kk);
        int b = bcyc(d);
        int p = bper(d);
        int r = kk;
        if (r < b) return ((r / p) % 2) == 0;
        r -= b;
        if (r < HOLD) return 1'b1;
        r -= HOLD;
        if (r < b) return ((r / p) % 2) == 1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_fila(int d, bit c);
        logic [3:0] f = 4'hF;
        logic [3:0] mc = mcode[d];
        if (c && !col[mc[1:0]]) f[mc[3:2]] = 1'b0;
        return f;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            active[d] = 1'b0;
            k[d]      = 0;
            mcode[d]  = 4'h0;
            mdone[d]  = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            bit c = active[d] && exp_contact(d, k[d]);
            chk($sformatf("ready%0d", d), rdy[d], !active[d]);
            chk($sformatf("busy%0d", d), bsy[d], active[d]);
            chk($sformatf("done%0d", d), don[d], mdone[d]);
            chk($sformatf("contact%0d", d), con[d], c);
            chk($sformatf("fila%0d", d), fil[d*4 +: 4],
                exp_fila(d, c));
        end
    endtask

    // Check at the falling edge, then advance model across the rising edge.
    task automatic cycle();
        bit acc [2];
        logic [3:0] kc;
        @(negedge clk);
        check_all();
        kc = key_code;
        for (int d = 0; d < 2; d++)
            acc[d] = rst && !active[d] && key_valid;
        @(posedge clk);
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                mdone[d] = 1'b0;
                if (active[d]) begin
                    k[d]++;
                    if (k[d] == total(d)) begin
                        active[d] = 1'b0;
                        mdone[d]  = 1'b1;
                    end
                end
                if (acc[d]) begin
                    active[d] = 1'b1;
                    k[d]      = 0;
                    mcode[d]  = kc;
                end
            end
        end
        #1;
    endtask

    function automatic logic [3:0] rand_col();
        case ($urandom_range(0, 3))
            0: return 4'b0000;
            1: return $urandom_range(0, 15);
            default: return ~(4'b0001 << $urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        int n;
        reset_model();
        col = 4'b0000;
        #12;
        check_all();
        #10;
        rst = 1'b1;
        repeat (3) cycle();

        key_code = 4'b0110; key_valid = 1'b1; col = 4'b1011;
        cycle();
        key_valid = 1'b0;
        repeat (50) cycle();

        key_code = 4'b0110; key_valid = 1'b1; col = 4'b1110;
        cycle();
        key_valid = 1'b0;
        repeat (50) cycle();

        key_code = 4'hF; key_valid = 1'b1; col = 4'b0111;
        cycle();
        key_code = 4'h0;
        for (int i = 0; i < 110; i++) begin
            col = (i % 2 == 0) ? 4'b0111 : 4'b1110;
            cycle();
        end
        key_valid = 1'b0;
        repeat (50) cycle();

        key_code = 4'h5; key_valid = 1'b1; col = 4'b1101;
        cycle();
        key_valid = 1'b0;
        n = 0;
        while (!(active[0] && k[0] == 5) && n < 100) begin
            cycle();
            n++;
        end
        chk("hold5_reached", n < 100, 1);
        chk("fila_before_rst", fil[3:0], 4'b1101);
        #2;
        rst = 1'b0;
        reset_model();
        #1;
        check_all();
        cycle();
        rst = 1'b1;
        repeat (60) cycle();

        for (int c = 0; c < 16; c++) begin
            key_code = 4'(c); key_valid = 1'b1;
            cycle();
            key_valid = 1'b0;
            for (int j = 0; j < 50; j++) begin
                col = ~(4'b0001 << (j % 4));
                cycle();
            end
        end

        repeat (3000) begin
            key_valid = ($urandom_range(0, 3) == 0);
            key_code  = 4'($urandom_range(0, 15));
            col       = rand_col();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
